// File: rtl/s4ga_cfg_streamer_if.sv
// Config-store read bus plus the serial stream toward the S4GA core pins.
// The streamer drives through the master modport; the config store and the
// core side sit on the slave modport.
interface s4ga_cfg_streamer_if #(
  parameter int N_W   = 9,
  parameter int CFG_W = 77,
  parameter int SI_W  = 4
);
  logic             cfg_rd;
  logic [N_W-1:0]   cfg_addr;
  logic [CFG_W-1:0] cfg_rdata;
  logic             fab_rst;
  logic [SI_W-1:0]  si;
  logic [N_W-1:0]   lut_n;
  logic             frame_start;

  modport master (
    output cfg_rd, cfg_addr, fab_rst, si, lut_n, frame_start,
    input  cfg_rdata
  );

  modport slave (
    input  cfg_rd, cfg_addr, fab_rst, si, lut_n, frame_start,
    output cfg_rdata
  );
endinterface

// File: rtl/s4ga_cfg_streamer.sv
// Transmit end of the S4GA configuration stream: prefetches one config word
// per LUT from a synchronous store, serializes it SI_W bits per clock in the
// order the core consumes it, and generates the core's fabric reset.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | stopped; fab_rst=1, si=0; waits for en
// S_HOLD   | fabric reset held RST_CYCLES cycles; LUT 0 word prefetched
// S_STREAM | segments streamed back to back, LUT N-1 wraps to LUT 0
module s4ga_cfg_streamer #(
  parameter int N          = 311,
  parameter int K          = 5,
  parameter int I          = 2,
  parameter int SI_W       = 4,
  parameter int RST_CYCLES = N + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 restart,
  s4ga_cfg_streamer_if.master  bus
);

  localparam int IDX_W     = $clog2(3 + I + N);
  localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
  localparam int MASK_W    = 2 ** K;
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
  localparam int LL        = K * IDX_SEGS + MASK_SEGS;
  localparam int CFG_W     = K * IDX_W + MASK_W;
  localparam int N_W       = $clog2(N);
  localparam int IDXP_W    = IDX_SEGS * SI_W;
  localparam int MASKP_W   = MASK_SEGS * SI_W;
  localparam int PAD_W     = LL * SI_W;
  localparam int CNT_MAX   = (RST_CYCLES > LL) ? RST_CYCLES : LL;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_STREAM
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_W-1:0]     lut_q, lut_d;
  logic [PAD_W-1:0]   cur_q, cur_d;
  logic [CFG_W-1:0]   nxt_q, nxt_d;
  logic               rvalid_q, rvalid_d;
  logic               cfg_rd_q, cfg_rd_d;
  logic [N_W-1:0]     cfg_addr_q, cfg_addr_d;
  logic               fab_rst_q, fab_rst_d;
  logic               frame_start_q, frame_start_d;
  logic               last_lut;

  // Re-lay a config word as LL whole segments: every index and the mask is
  // zero-padded at the top so each field starts on a segment boundary.
  function automatic logic [PAD_W-1:0] pad_word(input logic [CFG_W-1:0] w);
    logic [PAD_W-1:0] p;
    p = '0;
    for (int k = 0; k < K; k++) begin
      p[PAD_W-1-k*IDXP_W -: IDXP_W] = IDXP_W'(w[CFG_W-1-k*IDX_W -: IDX_W]);
    end
    p[MASKP_W-1:0] = MASKP_W'(w[MASK_W-1:0]);
    return p;
  endfunction

  // Next-state and next-output logic. Output flops are loaded from the
  // upcoming cycle's state so the pins line up with the state they describe.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lut_d         = lut_q;
    cur_d         = cur_q;
    nxt_d         = nxt_q;
    rvalid_d      = cfg_rd_q;
    cfg_rd_d      = 1'b0;
    cfg_addr_d    = cfg_addr_q;
    fab_rst_d     = 1'b1;
    frame_start_d = 1'b0;
    last_lut      = (lut_q == N_W'(N - 1));

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_STREAM;
          cnt_d   = '0;
          lut_d   = '0;
          cur_d   = pad_word(bus.cfg_rdata);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STREAM: begin
        cur_d = cur_q << SI_W;
        if (rvalid_q) nxt_d = bus.cfg_rdata;
        if (cnt_q == CNT_W'(LL - 1)) begin
          cnt_d = '0;
          // With LL=2 the prefetched word arrives on the last segment itself.
          cur_d = pad_word(rvalid_q ? bus.cfg_rdata : nxt_q);
          lut_d = last_lut ? '0 : lut_q + N_W'(1);
          if (last_lut && !en) begin
            state_d = S_IDLE;
            cur_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (restart && (state_q != S_IDLE)) begin
      state_d = en ? S_HOLD : S_IDLE;
      cnt_d   = '0;
      lut_d   = '0;
      cur_d   = '0;
    end

    case (state_d)
      S_HOLD: begin
        // Read goes out one cycle before the last HOLD cycle so the word is
        // on cfg_rdata exactly when the transition into STREAM latches it.
        if (cnt_d == CNT_W'(RST_CYCLES - 2)) begin
          cfg_rd_d   = 1'b1;
          cfg_addr_d = '0;
        end
      end
      S_STREAM: begin
        fab_rst_d = 1'b0;
        if (cnt_d == '0) begin
          cfg_rd_d      = 1'b1;
          cfg_addr_d    = (lut_d == N_W'(N - 1)) ? '0 : lut_d + N_W'(1);
          frame_start_d = (lut_d == '0);
        end
      end
      default: ;
    endcase
  end

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      lut_q         <= '0;
      cur_q         <= '0;
      nxt_q         <= '0;
      rvalid_q      <= 1'b0;
      cfg_rd_q      <= 1'b0;
      cfg_addr_q    <= '0;
      fab_rst_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lut_q         <= lut_d;
      cur_q         <= cur_d;
      nxt_q         <= nxt_d;
      rvalid_q      <= rvalid_d;
      cfg_rd_q      <= cfg_rd_d;
      cfg_addr_q    <= cfg_addr_d;
      fab_rst_q     <= fab_rst_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.cfg_rd      = cfg_rd_q;
  assign bus.cfg_addr    = cfg_addr_q;
  assign bus.fab_rst     = fab_rst_q;
  assign bus.si          = cur_q[PAD_W-1 -: SI_W];
  assign bus.lut_n       = lut_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
module tb_s4ga_cfg_streamer;

  localparam int N1   = 7;
  localparam int RST1 = N1 + 2;
  localparam int LL1  = 3;
  localparam int RST2 = 311 + 2;

  typedef struct {
    logic       fr;
    logic [3:0] si;
    logic [2:0] lut;
    logic       fs;
    logic       rd;
    logic [2:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst, en, restart, en2, restart2;

  s4ga_cfg_streamer_if #(.N_W(3), .CFG_W(12), .SI_W(4)) bus1 ();
  s4ga_cfg_streamer_if #(.N_W(9), .CFG_W(77), .SI_W(4)) bus2 ();

  s4ga_cfg_streamer #(.N(7), .K(2), .I(1), .SI_W(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .bus(bus1.master));

  s4ga_cfg_streamer dut2 (
    .clk(clk), .rst(rst), .en(en2), .restart(restart2), .bus(bus2.master));

  always #5 clk = ~clk;

  logic [11:0] rom1 [0:7];
  logic [76:0] w2;
  logic [91:0] exp2;

  always @(posedge clk) if (bus1.cfg_rd) bus1.cfg_rdata <= rom1[bus1.cfg_addr];
  always @(posedge clk) if (bus2.cfg_rd) bus2.cfg_rdata <= (bus2.cfg_addr == '0) ? w2 : '0;

  int n_cmp = 0;
  int n_fail = 0;
  exp_t q1[$];
  logic [3:0] q2[$];
  int hc, rdn, guard;
  logic [8:0] rdaddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_hold(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.fr = 1'b1; e.si = 4'h0; e.lut = 3'd0; e.fs = 1'b0;
      e.rd = (i == RST1 - 2); e.addr = 3'd0;
      q1.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.fr = 1'b1; e.si = 4'h0; e.lut = 3'd0; e.fs = 1'b0; e.rd = 1'b0; e.addr = 3'd0;
      q1.push_back(e);
    end
  endtask

  // Expected items for the first 'count' segments of a frame.
  task automatic push_frame(input int count);
    exp_t e;
    logic [11:0] w;
    int l, s;
    for (int i = 0; i < count; i++) begin
      l = i / LL1;
      s = i % LL1;
      w = rom1[l];
      e.fr   = 1'b0;
      e.si   = w[11-4*s -: 4];
      e.lut  = 3'(l);
      e.fs   = (l == 0) && (s == 0);
      e.rd   = (s == 0);
      e.addr = (l == N1 - 1) ? 3'd0 : 3'(l + 1);
      q1.push_back(e);
    end
  endtask

  task automatic step1();
    exp_t e;
    @(posedge clk);
    #1;
    if (q1.size() == 0) begin
      chk("dut1_queue_underrun", 32'd0, 32'd1);
    end else begin
      e = q1.pop_front();
      chk("dut1_fab_rst", 32'(bus1.fab_rst), 32'(e.fr));
      chk("dut1_si", 32'(bus1.si), 32'(e.si));
      chk("dut1_lut_n", 32'(bus1.lut_n), 32'(e.lut));
      chk("dut1_frame_start", 32'(bus1.frame_start), 32'(e.fs));
      chk("dut1_cfg_rd", 32'(bus1.cfg_rd), 32'(e.rd));
      if (e.rd) chk("dut1_cfg_addr", 32'(bus1.cfg_addr), 32'(e.addr));
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; restart = 1'b0; en2 = 1'b0; restart2 = 1'b0;
    rom1[0] = 12'h5A6;
    for (int i = 1; i < 8; i++) rom1[i] = 12'($urandom);
    w2   = {9'h123, 9'h0AB, 9'h1FF, 9'h000, 9'h155, 32'hDEADBEEF};
    exp2 = 92'h1230AB1FF000155DEADBEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_fab_rst", 32'(bus1.fab_rst), 32'd1);
    chk("rst_si", 32'(bus1.si), 32'd0);
    chk("rst_cfg_rd", 32'(bus1.cfg_rd), 32'd0);
    chk("rst_cfg_addr", 32'(bus1.cfg_addr), 32'd0);
    chk("rst_lut_n", 32'(bus1.lut_n), 32'd0);
    chk("rst_frame_start", 32'(bus1.frame_start), 32'd0);
    chk("rst_dut2_fab_rst", 32'(bus2.fab_rst), 32'd1);

    rst = 1'b1;
    push_idle(2);
    repeat (2) step1();

    // Default-parameter instance: LUT 0 word of the full-size configuration.
    en2 = 1'b1;
    for (int i = 0; i < 23; i++) q2.push_back(exp2[91-4*i -: 4]);
    hc = 0; rdn = 0; guard = 0; rdaddr = '1;
    do begin
      @(posedge clk);
      #1;
      if (bus2.fab_rst) begin
        hc++;
        if (bus2.cfg_rd) begin
          rdn++;
          rdaddr = bus2.cfg_addr;
        end
      end
      guard++;
    end while (bus2.fab_rst && guard < 400);
    chk("dut2_hold_len", 32'(hc), 32'(RST2));
    chk("dut2_hold_reads", 32'(rdn), 32'd1);
    chk("dut2_hold_addr", 32'(rdaddr), 32'd0);
    chk("dut2_frame_start", 32'(bus2.frame_start), 32'd1);
    for (int i = 0; i < 23; i++) begin
      chk("dut2_si", 32'(bus2.si), 32'(q2.pop_front()));
      chk("dut2_lut_n", 32'(bus2.lut_n), 32'd0);
      if (i < 22) begin
        @(posedge clk);
        #1;
      end
    end
    en2 = 1'b0;

    // HOLD then two full frames, covering the N-1 -> 0 wrap.
    en = 1'b1;
    push_hold(RST1);
    push_frame(N1 * LL1);
    push_frame(N1 * LL1);
    repeat (RST1 + 2 * N1 * LL1) step1();

    // Abort in the middle of LUT 3, re-reset, resume at LUT 0.
    push_frame(3 * LL1 + 2);
    repeat (3 * LL1 + 2) step1();
    restart = 1'b1;
    push_hold(RST1);
    push_frame(N1 * LL1);
    push_idle(3);
    step1();
    restart = 1'b0;
    repeat (RST1 - 1) step1();
    repeat (3 * LL1) step1();
    en = 1'b0;
    repeat ((N1 - 3) * LL1 + 3) step1();

    // restart is ignored in IDLE.
    push_idle(3);
    restart = 1'b1;
    step1();
    restart = 1'b0;
    repeat (2) step1();

    // restart together with en=0 during HOLD returns to IDLE.
    en = 1'b1;
    push_hold(2);
    repeat (2) step1();
    restart = 1'b1;
    en = 1'b0;
    push_idle(2);
    step1();
    restart = 1'b0;
    step1();

    chk("dut1_queue_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
